// File: rtl/control_unit.sv
// Sequencing controller for the microc datapath: decodes Opcode and flags into control strobes.
// Optional retired-instruction counter enabled by defining CONTROL_UNIT_COUNT_EN.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] Opcode,
  input  logic       zero,
  input  logic       carry,
  output logic       pc_en,
  output logic       s_inc,
  output logic       s_skip,
  output logic       s_inm,
  output logic       we,
  output logic [2:0] ALUOp,
  output logic       busy
`ifdef CONTROL_UNIT_COUNT_EN
  ,
  output logic [15:0] retired
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic [1:0] state_q, state_d;
  logic       cond_taken;

  // In SKIP the flags already hold the result of the compare cycle.
  always_comb begin
    case (Opcode[1:0])
      2'b00:   cond_taken = zero;
      2'b01:   cond_taken = ~zero;
      2'b10:   cond_taken = carry;
      default: cond_taken = ~carry;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    s_inc   = 1'b0;
    s_skip  = 1'b0;
    s_inm   = 1'b0;
    we      = 1'b0;
    ALUOp   = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        casez (Opcode)
          6'b1?????: begin
            pc_en = 1'b1;
            s_inc = 1'b1;
            we    = 1'b1;
            ALUOp = Opcode[2:0];
          end
          6'b000???: begin
            pc_en = 1'b1;
          end
          6'b001???: begin
            pc_en = 1'b1;
            s_inc = 1'b1;
            s_inm = 1'b1;
            we    = 1'b1;
          end
          6'b0100??: begin
            ALUOp   = 3'b011;
            state_d = ST_SKIP;
          end
          6'b011111: begin
            state_d = ST_HALT;
          end
          default: begin
            pc_en = 1'b1;
            s_inc = 1'b1;
          end
        endcase
      end
      ST_SKIP: begin
        pc_en   = 1'b1;
        s_inc   = 1'b1;
        ALUOp   = 3'b011;
        s_skip  = cond_taken;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_SKIP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

`ifdef CONTROL_UNIT_COUNT_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (pc_en) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_q <= 16'd0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: decode table, corner sequences and a randomized run
// compared against an opcode-range reference model.
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] Opcode;
  logic       zero;
  logic       carry;
  logic       pc_en, s_inc, s_skip, s_inm, we, busy;
  logic [2:0] ALUOp;
`ifdef CONTROL_UNIT_COUNT_EN
  logic [15:0] retired;
`endif

  control_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Opcode (Opcode),
    .zero   (zero),
    .carry  (carry),
    .pc_en  (pc_en),
    .s_inc  (s_inc),
    .s_skip (s_skip),
    .s_inm  (s_inm),
    .we     (we),
    .ALUOp  (ALUOp),
    .busy   (busy)
`ifdef CONTROL_UNIT_COUNT_EN
    ,
    .retired(retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, s_inc, s_skip, s_inm, we, ALUOp, busy}
  logic [8:0] obs;
  assign obs = {pc_en, s_inc, s_skip, s_inm, we, ALUOp, busy};

  int checks = 0;
  int failures = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_SKIP = 2, M_HALT = 3;

  typedef struct {
    logic [5:0] op;
    logic       two;
    logic       z;
    logic       c;
    logic [8:0] exp1;
    logic [8:0] exp2;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected outputs from mode and the opcode's numeric range.
  function automatic logic [8:0] model(input int mode, input int op, input bit z, input bit c);
    bit pe = 0, si = 0, sk = 0, im = 0, w = 0, b = 0;
    int alu = 0;
    bit taken;
    if (mode == M_RUN) begin
      b = 1;
      if (op >= 32) begin pe = 1; si = 1; w = 1; alu = op % 8; end
      else if (op < 8) pe = 1;
      else if (op < 16) begin pe = 1; si = 1; im = 1; w = 1; end
      else if (op < 20) alu = 3;
      else if (op == 31) ;
      else begin pe = 1; si = 1; end
    end else if (mode == M_SKIP) begin
      b = 1;
      case (op % 4)
        0: taken = z;
        1: taken = !z;
        2: taken = c;
        default: taken = !c;
      endcase
      pe = 1; si = 1; alu = 3; sk = taken;
    end
    return {pe, si, sk, im, w, alu[2:0], b};
  endfunction

  function automatic int next_mode(input int mode, input int op, input bit st);
    if (mode == M_IDLE) return st ? M_RUN : M_IDLE;
    if (mode == M_SKIP) return M_RUN;
    if (mode == M_RUN) begin
      if (op >= 16 && op < 20) return M_SKIP;
      if (op == 31) return M_HALT;
      return M_RUN;
    end
    return M_HALT;
  endfunction

  task automatic do_reset_and_start();
    #2;
    reset = 1'b0;
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int mode;
  int op;
  bit z, c, st;
  logic [8:0] e;
  logic [15:0] cnt;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    Opcode = 6'd0;
    zero   = 1'b0;
    carry  = 1'b0;

    vecs[0] = '{6'b001000, 1'b0, 1'b0, 1'b0, 9'b1_1_0_1_1_000_1, 9'd0};
    vecs[1] = '{6'b100010, 1'b0, 1'b0, 1'b0, 9'b1_1_0_0_1_010_1, 9'd0};
    vecs[2] = '{6'b111101, 1'b0, 1'b0, 1'b0, 9'b1_1_0_0_1_101_1, 9'd0};
    vecs[3] = '{6'b000011, 1'b0, 1'b0, 1'b0, 9'b1_0_0_0_0_000_1, 9'd0};
    vecs[4] = '{6'b010100, 1'b0, 1'b0, 1'b0, 9'b1_1_0_0_0_000_1, 9'd0};
    vecs[5] = '{6'b011110, 1'b0, 1'b0, 1'b0, 9'b1_1_0_0_0_000_1, 9'd0};
    vecs[6] = '{6'b010001, 1'b1, 1'b0, 1'b0, 9'b0_0_0_0_0_011_1, 9'b1_1_1_0_0_011_1};
    vecs[7] = '{6'b010001, 1'b1, 1'b1, 1'b0, 9'b0_0_0_0_0_011_1, 9'b1_1_0_0_0_011_1};
    vecs[8] = '{6'b010000, 1'b1, 1'b1, 1'b0, 9'b0_0_0_0_0_011_1, 9'b1_1_1_0_0_011_1};
    vecs[9] = '{6'b010011, 1'b1, 1'b0, 1'b1, 9'b0_0_0_0_0_011_1, 9'b1_1_0_0_0_011_1};

    // Reset, then idle with start low
    step();
    chk("reset_outputs", {7'd0, obs}, 16'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("idle_outputs", {7'd0, obs}, 16'd0);
`ifdef CONTROL_UNIT_COUNT_EN
    chk("idle_retired", retired, 16'd0);
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", {15'd0, busy}, 16'd1);

    // Decode table
    foreach (vecs[i]) begin
      Opcode = vecs[i].op;
      zero   = 1'($urandom);
      carry  = 1'($urandom);
      #1;
      chk($sformatf("vec%0d_c1", i), {7'd0, obs}, {7'd0, vecs[i].exp1});
      if (vecs[i].two) begin
        step();
        zero  = vecs[i].z;
        carry = vecs[i].c;
        #1;
        chk($sformatf("vec%0d_c2", i), {7'd0, obs}, {7'd0, vecs[i].exp2});
      end
      step();
    end

    // Halt: start is ignored afterwards
    Opcode = 6'b011111;
    #1;
    chk("halt_run_cycle", {7'd0, obs}, 16'h0001);
    step();
    chk("halt_outputs", {7'd0, obs}, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    Opcode = 6'b001000;
    #1;
    chk("halt_start_ignored", {7'd0, obs}, 16'd0);

    // Reset mid-skip
    do_reset_and_start();
    Opcode = 6'b010010;
    carry  = 1'b1;
    step();
    #1;
    chk("skipc_c2_taken", {7'd0, obs}, {7'd0, 9'b1_1_1_0_0_011_1});
    reset = 1'b0;
    #1;
    chk("reset_mid_skip", {7'd0, obs}, 16'd0);
`ifdef CONTROL_UNIT_COUNT_EN
    chk("reset_mid_skip_retired", retired, 16'd0);
`endif
    step();
    reset = 1'b1;
    step();
    chk("after_reset_idle", {7'd0, obs}, 16'd0);

`ifdef CONTROL_UNIT_COUNT_EN
    // 3 li, 1 skip, 1 jr
    do_reset_and_start();
    Opcode = 6'b001000;
    for (int i = 0; i < 3; i++) step();
    Opcode = 6'b010000;
    step();
    step();
    Opcode = 6'b000011;
    step();
    chk("retired_5", retired, 16'd5);
`endif

    // Randomized run against the reference model
    do_reset_and_start();
    mode = M_RUN;
    cnt  = 16'd0;
    op   = 0;
    for (int n = 0; n < 400; n++) begin
      if (mode != M_SKIP) begin
        op = int'($urandom_range(0, 62));
        if (op == 31) op = 63;
      end
      z  = 1'($urandom);
      c  = 1'($urandom);
      st = 1'($urandom);
      Opcode = 6'(op);
      zero   = z;
      carry  = c;
      start  = st;
      #1;
      e = model(mode, op, z, c);
      chk($sformatf("rand%0d", n), {7'd0, obs}, {7'd0, e});
      if (e[8]) cnt = cnt + 16'd1;
      step();
      mode = next_mode(mode, op, st);
`ifdef CONTROL_UNIT_COUNT_EN
      if (n % 50 == 49) chk($sformatf("rand_retired%0d", n), retired, cnt);
`endif
    end
    start = 1'b0;

`ifdef CONTROL_UNIT_COUNT_EN
    // Counter wrap over 65536 nops
    do_reset_and_start();
    Opcode = 6'b010100;
    for (int i = 0; i < 65535; i++) step();
    chk("retired_ffff", retired, 16'hFFFF);
    step();
    chk("retired_wrap", retired, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing controller for the `microc` datapath. Decodes the 6-bit `Opcode` and the registered `zero`/`carry` flags into `s_inc`, `s_skip`, `s_inm`, `we`, `ALUOp` and a PC write enable. Runs a small FSM (IDLE/RUN/SKIP/HALT) that makes conditional skips two-cycle and stops the core on `halt`. Sits beside `microc` in the CPU top level, replacing the hand-driven control stimulus.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution; sampled only in IDLE.
- `Opcode`  in  6  current instruction opcode from the datapath.
- `zero`  in  1  registered ALU zero flag from the datapath.
- `carry`  in  1  registered ALU carry flag from the datapath.
- `pc_en`  out  1  PC register write enable in the datapath.
- `s_inc`  out  1  1 = PC+1 path, 0 = jump target.
- `s_skip`  out  1  1 = PC+2 (skip taken).
- `s_inm`  out  1  1 = immediate to register-file write port.
- `we`  out  1  register-file write enable.
- `ALUOp`  out  3  ALU operation.
- `busy`  out  1  high in RUN and SKIP.
- `retired`  out  16  retired-instruction count; present only with `CONTROL_UNIT_COUNT_EN`.

## Operation
- Outputs are combinational from state and `Opcode` (Mealy). Any output not listed for a case is 0.
- IDLE (reset state): all outputs 0. `start`=1 → RUN.
- RUN, decoded by `Opcode`:
  - `000xxx` j/jr: `pc_en`=1, `s_inc`=0. Stay RUN.
  - `001xxx` li: `pc_en`=1, `s_inc`=1, `s_inm`=1, `we`=1, `ALUOp`=000. Stay RUN.
  - `1xxaaa` ALU: `pc_en`=1, `s_inc`=1, `we`=1, `ALUOp`=aaa. Stay RUN.
  - `0100cc` skip (cc: 00 skipz, 01 skipnz, 10 skipc, 11 skipnc): `pc_en`=0, `ALUOp`=011, `we`=0. Go to SKIP.
  - `011111` halt: `pc_en`=0. Go to HALT.
  - `0101xx`, `011000`–`011110` (reserved): treated as nop, i.e. `pc_en`=1, `s_inc`=1. Stay RUN.
- SKIP: `Opcode` still holds the skip, because the PC was not written. Evaluate cc against the flags latched by the previous cycle's compare. Drive `pc_en`=1, `s_inc`=1, `ALUOp`=011, `s_skip`=condition. Return to RUN.
- HALT: all outputs 0. Leave only via reset; `start` is ignored.
- `start` is ignored in RUN and SKIP.

## Timing
- Decode latency is 0 cycles: outputs follow `Opcode` within the same cycle.
- Single-cycle instructions retire on the rising edge where `pc_en`=1.
- Skips take exactly 2 cycles: compare, then PC update.
- Flag usage: the datapath registers `zero`/`carry` at the end of the compare cycle. SKIP uses those values; flag changes during SKIP itself do not affect the decision.
- Reset assertion at any point, including mid-skip: state → IDLE immediately (asynchronous), all outputs 0 in the same instant, `retired` → 0. The datapath PC is not written.
- Reset release: the first RUN cycle is the cycle after `start` is sampled high on a rising edge.

## Configuration
- `CONTROL_UNIT_COUNT_EN` defined:
  - 16-bit `retired` port and counter exist.
  - Counter increments on every rising edge with `pc_en`=1, in both RUN and SKIP; a skip counts once.
  - Wraps 16'hFFFF → 0. Holds in IDLE/HALT. Reset value 0.
- Undefined: no `retired` port and no counter logic.

## Test plan
- Reset low, then high with `start`=0 for 5 cycles → IDLE, all outputs 0, `busy`=0. Pulse `start` → `busy`=1 on the next edge.
- RUN with `Opcode`=001000 (li) → `pc_en`=1, `s_inm`=1, `we`=1, `ALUOp`=000. Then `Opcode`=100010 (add) → `we`=1, `ALUOp`=010, `s_inm`=0.
- `Opcode`=010001 (skipnz) with `zero` latched 0 → cycle 1: `pc_en`=0, `ALUOp`=011. Cycle 2: `pc_en`=1, `s_skip`=1. Repeat with `zero`=1 → cycle 2 `s_skip`=0.
- `Opcode`=000011 (jr) → `pc_en`=1, `s_inc`=0. Then `Opcode`=011111 (halt) → HALT; pulsing `start` changes nothing, all outputs stay 0.
- Assert reset during the SKIP cycle of a skipc → outputs 0 immediately, state IDLE, `retired`=0.
- With `CONTROL_UNIT_COUNT_EN`: 3 li, 1 skip, 1 jr → `retired`=5. Preload-free run of 65 536 nops → `retired` wraps to 0.
